// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state type, Booth triplet codes and iteration-count helper
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [2:0] BT_ZERO0 = 3'b000;
  localparam logic [2:0] BT_POS1A = 3'b001;
  localparam logic [2:0] BT_POS1B = 3'b010;
  localparam logic [2:0] BT_POS2  = 3'b011;
  localparam logic [2:0] BT_NEG2  = 3'b100;
  localparam logic [2:0] BT_NEG1A = 3'b101;
  localparam logic [2:0] BT_NEG1B = 3'b110;
  localparam logic [2:0] BT_ZERO1 = 3'b111;

  // Unsigned operands need one extra step to consume the zero-extended top triplet.
  function automatic int num_iter(input int width, input logic is_signed);
    return is_signed ? width / 2 : width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_decode.sv
// rtl/booth_r4_decode.sv - radix-4 Booth triplet to partial-product control decode
module booth_r4_decode
  import booth_pkg::*;
(
  input  logic [2:0] bits,
  output logic       zero,
  output logic       mltnd_shift,
  output logic       sub
);

  always_comb begin
    zero        = 1'b0;
    mltnd_shift = 1'b0;
    sub         = 1'b0;
    case (bits)
      BT_ZERO0, BT_ZERO1: zero = 1'b1;
      BT_POS1A, BT_POS1B: ;
      BT_POS2:            mltnd_shift = 1'b1;
      BT_NEG2: begin
        mltnd_shift = 1'b1;
        sub         = 1'b1;
      end
      BT_NEG1A, BT_NEG1B: sub = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq_ctrl.sv
// rtl/booth_mult_seq_ctrl.sv - radix-4 Booth sequencing controller (IDLE/INIT/RUN/FINISH)
// Optional abort input enabled by defining BOOTH_ABORT_EN.
module booth_mult_seq_ctrl
  import booth_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH / 2 + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_mult,
  input  logic          is_signed,
  input  logic [2:0]    bits,
`ifdef BOOTH_ABORT_EN
  input  logic          abort,
`endif
  output logic          ready,
  output logic          busy,
  output logic          init_cycle,
  output logic          mltnd_shift,
  output logic          sub,
  output logic          zero,
  output logic          finish_cyc,
  output logic          done,
  output logic [CW-1:0] iter
);

  localparam logic [CW-1:0] LAST_S = CW'(num_iter(WIDTH, 1'b1) - 1);
  localparam logic [CW-1:0] LAST_U = CW'(num_iter(WIDTH, 1'b0) - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          mode_q, mode_d;
  logic          done_q;
  logic          abort_req;
  logic [CW-1:0] last_iter;
  logic          in_run;
  logic          dec_zero, dec_shift, dec_sub;

`ifdef BOOTH_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign last_iter = mode_q ? LAST_S : LAST_U;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d = INIT;
          mode_d  = is_signed;
          iter_d  = '0;
        end
      end
      INIT: begin
        iter_d  = '0;
        state_d = abort_req ? IDLE : RUN;
      end
      RUN: begin
        // Abort wins over the last-iteration exit so no FINISH is ever produced.
        if (abort_req) begin
          state_d = IDLE;
          iter_d  = '0;
        end else if (iter_q == last_iter) begin
          state_d = FINISH;
        end else begin
          iter_d = iter_q + CW'(1);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      mode_q  <= mode_d;
      done_q  <= (state_q == FINISH);
    end
  end

  booth_r4_decode u_decode (
    .bits        (bits),
    .zero        (dec_zero),
    .mltnd_shift (dec_shift),
    .sub         (dec_sub)
  );

  assign in_run      = (state_q == RUN);
  assign ready       = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign init_cycle  = (state_q == INIT);
  assign finish_cyc  = (state_q == FINISH);
  assign done        = done_q;
  assign iter        = iter_q;
  assign zero        = in_run & dec_zero;
  assign mltnd_shift = in_run & dec_shift;
  assign sub         = in_run & dec_sub;

endmodule

// File: tb/tb_booth_mult_seq_ctrl.sv
// tb/tb_booth_mult_seq_ctrl.sv - bench for booth_mult_seq_ctrl at WIDTH 32, 8 and 4
module tb_booth_mult_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] bits;
  logic       abort;
  logic       start  [3];
  logic       sgn    [3];
  logic       ready_o[3], busy_o[3], init_o[3], shift_o[3], sub_o[3], zero_o[3], fin_o[3], done_o[3];
  logic [7:0] iter_o [3];

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;
  int ph[3];
  int nn[3];

`ifdef BOOTH_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W   = (g == 0) ? 32 : ((g == 1) ? 8 : 4);
    localparam int CWG = $clog2(W / 2 + 2);
    logic [CWG-1:0] it;
    booth_mult_seq_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_mult  (start[g]),
      .is_signed   (sgn[g]),
      .bits        (bits),
`ifdef BOOTH_ABORT_EN
      .abort       (abort),
`endif
      .ready       (ready_o[g]),
      .busy        (busy_o[g]),
      .init_cycle  (init_o[g]),
      .mltnd_shift (shift_o[g]),
      .sub         (sub_o[g]),
      .zero        (zero_o[g]),
      .finish_cyc  (fin_o[g]),
      .done        (done_o[g]),
      .iter        (it)
    );
    assign iter_o[g] = 8'(it);
  end

  function automatic int wof(input int i);
    return (i == 0) ? 32 : ((i == 1) ? 8 : 4);
  endfunction

  // Reference timeline: ph = cycles since accept (0 = idle, 1 = init,
  // 2..n+1 = run, n+2 = finish, n+3 = done/idle).
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        ph[i] = 0;
      end else if (ph[i] == 0 || ph[i] == nn[i] + 3) begin
        if (start[i]) begin
          ph[i] = 1;
          nn[i] = wof(i) / 2 + (sgn[i] ? 0 : 1);
        end else begin
          ph[i] = 0;
        end
      end else if (ABORT_EN && abort && ph[i] <= nn[i] + 1) begin
        ph[i] = 0;
      end else begin
        ph[i] = ph[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 3; i++) begin
        int p, n, v, b2, b1, b0;
        bit run;
        logic [16:0] exp_v, act_v;
        p   = ph[i];
        n   = nn[i];
        run = (p >= 2) && (p <= n + 1);
        b2 = int'(bits[2]); b1 = int'(bits[1]); b0 = int'(bits[0]);
        v   = -2 * b2 + b1 + b0;
        exp_v = {(p == 0 || p == n + 3), (p >= 1 && p <= n + 2), (p == 1), (p == n + 2),
                 (p == n + 3), (run && v == 0), (run && (v == 2 || v == -2)), (run && v < 0),
                 1'b1, (run ? 8'(p - 2) : 8'h00)};
        act_v = {ready_o[i], busy_o[i], init_o[i], fin_o[i], done_o[i], zero_o[i], shift_o[i],
                 sub_o[i], (iter_o[i] <= 8'(wof(i) / 2)), (run ? iter_o[i] : 8'h00)};
        n_cmp++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL cycle_model w=%0d t=%0t act=%h exp=%h", wof(i), $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input int i);
    int c;
    c = 0;
    while (!(ready_o[i] === 1'b1) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("idle_reached", 32'(ready_o[i]), 32'd1);
  endtask

  task automatic start_op(input int i, input bit s);
    @(posedge clk); #1;
    start[i] = 1'b1;
    sgn[i]   = s;
    @(posedge clk); #1;
    start[i] = 1'b0;
    sgn[i]   = ~s;
  endtask

  task automatic run_op(input int i, input bit s, input int nexp);
    int c, fc, dc, rc, ic, mx;
    start_op(i, s);
    c = 0; fc = -1; dc = -1; rc = 0; ic = -1; mx = -1;
    while (dc < 0 && c < 200) begin
      @(negedge clk);
      c++;
      if (init_o[i]) ic = c;
      if (fin_o[i]) fc = c;
      if (done_o[i]) dc = c;
      if (busy_o[i] && !init_o[i] && !fin_o[i]) begin
        rc++;
        if (int'(iter_o[i]) > mx) mx = int'(iter_o[i]);
      end
    end
    chk($sformatf("init_at_w%0d", wof(i)), 32'(ic), 32'd1);
    chk($sformatf("run_cycles_w%0d_s%0d", wof(i), s), 32'(rc), 32'(nexp));
    chk($sformatf("iter_max_w%0d_s%0d", wof(i), s), 32'(mx), 32'(nexp - 1));
    chk($sformatf("finish_at_w%0d_s%0d", wof(i), s), 32'(fc), 32'(nexp + 2));
    chk($sformatf("done_at_w%0d_s%0d", wof(i), s), 32'(dc), 32'(nexp + 3));
  endtask

  typedef struct {
    logic [2:0] b;
    logic       z;
    logic       sh;
    logic       sb;
  } dec_vec_t;

  initial begin
    dec_vec_t tbl[8];
    int cnt, exp_cnt, inits, exp_inits;

    tbl[0] = '{3'b000, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{3'b001, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{3'b010, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{3'b011, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{3'b100, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{3'b101, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{3'b110, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{3'b111, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    bits  = 3'b000;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      sgn[i]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outs_w%0d", wof(i)),
          32'({ready_o[i], busy_o[i], init_o[i], fin_o[i], done_o[i],
               zero_o[i], shift_o[i], sub_o[i], iter_o[i]}),
          32'({1'b1, 7'b0, 8'h00}));
    rst_n    = 1'b1;
    check_en = 1'b1;

    // Full operations: timing, iteration counts, mode captured at accept only
    run_op(0, 1'b1, 16);
    run_op(0, 1'b0, 17);
    run_op(1, 1'b1, 4);
    run_op(2, 1'b1, 2);
    run_op(2, 1'b0, 3);

    // Decode sweep during RUN, then all-zero while idle
    start_op(0, 1'b1);
    @(posedge clk); #1;
    for (int j = 0; j < 8; j++) begin
      bits = tbl[j].b;
      @(negedge clk);
      chk($sformatf("decode_run_b%0d", j), 32'({zero_o[0], shift_o[0], sub_o[0]}),
          32'({tbl[j].z, tbl[j].sh, tbl[j].sb}));
      @(posedge clk); #1;
    end
    wait_idle(0);
    for (int j = 0; j < 8; j++) begin
      bits = tbl[j].b;
      #1;
      chk($sformatf("decode_idle_b%0d", j), 32'({zero_o[0], shift_o[0], sub_o[0]}), 32'd0);
    end

    // Asynchronous reset in the middle of RUN
    start_op(0, 1'b1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy_o[0]), 32'd0);
    chk("rst_mid_ready", 32'(ready_o[0]), 32'd1);
    chk("rst_mid_iter", 32'(iter_o[0]), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_o[0] || fin_o[0]) cnt++;
    end
    chk("no_done_after_rst", 32'(cnt), 32'd0);

    // start_mult held high: back-to-back WIDTH=8 signed operations, period N+3
    @(posedge clk); #1;
    start[1] = 1'b1;
    sgn[1]   = 1'b1;
    @(posedge clk);
    cnt = 0; inits = 0; exp_cnt = 0; exp_inits = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done_o[1]) cnt++;
      if (init_o[1]) inits++;
      if (c % 7 == 0) exp_cnt++;
      if (c % 7 == 1) exp_inits++;
    end
    chk("b2b_done_count", 32'(cnt), 32'(exp_cnt));
    chk("b2b_init_count", 32'(inits), 32'(exp_inits));
    @(posedge clk); #1 start[1] = 1'b0;
    wait_idle(1);

`ifdef BOOTH_ABORT_EN
    begin
      int c;
      start_op(0, 1'b1);
      c = 0;
      while (!(iter_o[0] == 8'd5 && busy_o[0] && !init_o[0] && !fin_o[0]) && c < 50) begin
        @(negedge clk);
        c++;
      end
      chk("abort_reach_iter5", 32'(iter_o[0]), 32'd5);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      chk("abort_ready", 32'(ready_o[0]), 32'd1);
      cnt = 0;
      repeat (20) begin
        @(negedge clk);
        if (done_o[0] || fin_o[0]) cnt++;
      end
      chk("abort_no_finish", 32'(cnt), 32'd0);
      run_op(0, 1'b1, 16);
    end
`endif

    // Randomised traffic on all three instances against the timeline model
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        start[i] = ($urandom_range(0, 3) == 0);
        sgn[i]   = 1'($urandom_range(0, 1));
      end
      bits  = 3'($urandom_range(0, 7));
      abort = ABORT_EN && ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    for (int i = 0; i < 3; i++) wait_idle(i);

    @(negedge clk);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
